down_timer: RTL and testbench

Loadable down-counter and timer: the counting-down counterpart to the free-running up-counters already in the design. It is loaded with a start value and counts down to zero on each rising clock edge. It flags terminal count and either stops or auto-reloads to produce a periodic tick. It supplies timeouts and periodic strobes to control logic in the same clock domain.

---
 rtl/down_timer_pkg.sv | 29 ++
 rtl/down_timer_if.sv | 31 +++
 rtl/down_timer_core.sv | 68 ++++++
 rtl/down_timer.sv | 138 +++++++++++++
 tb/tb_down_timer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/down_timer_pkg.sv
// -----------------------------------------------------------------------------
// down_timer_pkg
// Shared types and constants for the loadable down-counter / timer.
//   DT_WIDTH   : default counter and load-value width
//   dt_state_e : controller states
//   dt_op_e    : datapath operation chosen by the controller each cycle
// -----------------------------------------------------------------------------
package down_timer_pkg;

  localparam int DT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_DONE
  } dt_state_e;

  // One operation per edge keeps the Load > terminal-count > Pause > Start
  // priority in a single place (the controller), not spread over the datapath.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_DEC,
    OP_RELOAD,
    OP_CLEAR
  } dt_op_e;

endpackage

// File: rtl/down_timer_if.sv
// -----------------------------------------------------------------------------
// down_timer_if
// Control/status bundle of the down-timer.
//   master : drives Load, Load_Val, Start, Pause, Auto_Reload; reads status
//   slave  : the timer; reads controls, drives Y, Tc, Busy, Done
// -----------------------------------------------------------------------------
interface down_timer_if #(
  parameter int WIDTH = down_timer_pkg::DT_WIDTH
);

  logic             Load;
  logic [WIDTH-1:0] Load_Val;
  logic             Start;
  logic             Pause;
  logic             Auto_Reload;
  logic [WIDTH-1:0] Y;
  logic             Tc;
  logic             Busy;
  logic             Done;

  modport master (
    output Load, Load_Val, Start, Pause, Auto_Reload,
    input  Y, Tc, Busy, Done
  );

  modport slave (
    input  Load, Load_Val, Start, Pause, Auto_Reload,
    output Y, Tc, Busy, Done
  );

endinterface

// File: rtl/down_timer_core.sv
// -----------------------------------------------------------------------------
// down_timer_core
// Datapath of the down-timer: count register, reload register, decrementer
// and the compares the controller needs.
//   clk, rst_n        : clock, async active-low reset
//   op_i              : operation for this edge (hold/load/dec/reload/clear)
//   load_val_i        : value captured on OP_LOAD
//   y_o               : registered count
//   y_is_one_o        : count equals 1 (terminal-count step pending)
//   y_is_zero_o       : count equals 0
//   rld_is_zero_o     : reload register equals 0
//   load_val_zero_o   : load_val_i equals 0
// -----------------------------------------------------------------------------
module down_timer_core
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  dt_op_e           op_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] y_o,
  output logic             y_is_one_o,
  output logic             y_is_zero_o,
  output logic             rld_is_zero_o,
  output logic             load_val_zero_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] rld_q, rld_d;

  always_comb begin
    y_d   = y_q;
    rld_d = rld_q;
    unique case (op_i)
      OP_LOAD: begin
        y_d   = load_val_i;
        rld_d = load_val_i;
      end
      // The controller only decrements above 1; the guard keeps the count
      // from ever wrapping even if that changes.
      OP_DEC:    if (y_q != '0) y_d = y_q - ONE;
      OP_RELOAD: y_d = rld_q;
      OP_CLEAR:  y_d = '0;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      rld_q <= '0;
    end else begin
      y_q   <= y_d;
      rld_q <= rld_d;
    end
  end

  assign y_o             = y_q;
  assign y_is_one_o      = (y_q == ONE);
  assign y_is_zero_o     = (y_q == '0);
  assign rld_is_zero_o   = (rld_q == '0);
  assign load_val_zero_o = (load_val_i == '0);

endmodule

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
// Loadable down-counter with one-shot / auto-reload terminal count.
//   Clk   : clock, all state changes on the rising edge
//   Rst_n : async active-low reset
//   bus   : down_timer_if.slave
//           in : Load, Load_Val, Start, Pause, Auto_Reload
//           out: Y (count), Tc (1-cycle terminal count), Busy (RUN/HOLD),
//                Done (level, DONE)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped, waiting for Load/Start
// RUN   | counting down one per edge
// HOLD  | paused, count frozen
// DONE  | one-shot finished, Y = 0, Start restarts from reload register
// -----------------------------------------------------------------------------
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DT_WIDTH
) (
  input  logic         Clk,
  input  logic         Rst_n,
  down_timer_if.slave  bus
);

  dt_state_e        state_q, state_d;
  dt_op_e           op;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] y;
  logic             y_is_one;
  logic             y_is_zero;
  logic             rld_is_zero;
  logic             lv_zero;

  down_timer_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk             (Clk),
    .rst_n           (Rst_n),
    .op_i            (op),
    .load_val_i      (bus.Load_Val),
    .y_o             (y),
    .y_is_one_o      (y_is_one),
    .y_is_zero_o     (y_is_zero),
    .rld_is_zero_o   (rld_is_zero),
    .load_val_zero_o (lv_zero)
  );

  // State register and registered flags.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // A same-cycle Load supplies the value Start looks at.
        if (bus.Load)
          state_d = (bus.Start && !lv_zero) ? ST_RUN : ST_IDLE;
        else if (bus.Start && !y_is_zero)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.Load)
          state_d = lv_zero ? ST_IDLE : ST_RUN;
        else if (y_is_one)
          state_d = bus.Auto_Reload ? ST_RUN : ST_DONE;
        else if (bus.Pause)
          state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Leaving HOLD takes the step on the same edge, so a pause that is
        // sampled high for P edges delays terminal count by exactly P.
        if (bus.Load)
          state_d = lv_zero ? ST_IDLE : ST_HOLD;
        else if (!bus.Pause)
          state_d = (y_is_one && !bus.Auto_Reload) ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        if (bus.Load)
          state_d = (bus.Start && !lv_zero) ? ST_RUN : ST_IDLE;
        else if (bus.Start && !rld_is_zero)
          state_d = ST_RUN;
      end
    endcase
  end

  // Output / datapath-command logic.
  always_comb begin
    op   = OP_HOLD;
    tc_d = 1'b0;
    if (bus.Load) begin
      op = OP_LOAD;
    end else begin
      unique case (state_q)
        ST_RUN, ST_HOLD: begin
          // Terminal count beats Pause while running; in HOLD only a
          // released Pause lets the step happen.
          if ((state_q == ST_RUN) || !bus.Pause) begin
            if (y_is_one) begin
              tc_d = 1'b1;
              op   = bus.Auto_Reload ? OP_RELOAD : OP_CLEAR;
            end else if (!bus.Pause) begin
              op = OP_DEC;
            end
          end
        end
        ST_DONE: if (bus.Start && !rld_is_zero) op = OP_RELOAD;
        default: ;
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    done_d = (state_d == ST_DONE);
  end

  assign bus.Y    = y;
  assign bus.Tc   = tc_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] y;
    logic         tc;
    logic         busy;
    logic         done;
  } obs_t;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         st;
    logic         ps;
    logic         ar;
    obs_t         exp;
  } vec_t;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];

  down_timer_if #(.WIDTH(W)) bus ();

  down_timer #(.WIDTH(W)) u_dut (
    .Clk   (clk_sys),
    .Rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic obs_t sample();
    return {bus.Y, bus.Tc, bus.Busy, bus.Done};
  endfunction

  function automatic vec_t mk(bit ld, int lv, bit st, bit ps, bit ar,
                              int y, bit tc, bit busy, bit done);
    vec_t v;
    v.ld  = ld;
    v.lv  = W'(lv);
    v.st  = st;
    v.ps  = ps;
    v.ar  = ar;
    v.exp = {W'(y), tc, busy, done};
    return v;
  endfunction

  // Applies one cycle of stimulus and records what the next edge must produce.
  task automatic drive(input vec_t v);
    bus.Load        = v.ld;
    bus.Load_Val    = v.lv;
    bus.Start       = v.st;
    bus.Pause       = v.ps;
    bus.Auto_Reload = v.ar;
    exp_q.push_back(v.exp);
  endtask

  task automatic test_reset();
    vec_t v[$];
    obs_t got, want;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    got = sample(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_init: got Y=%0d Tc=%b Busy=%b Done=%b, want all 0",
               got.y, got.tc, got.busy, got.done);
    end
    @(negedge clk_sys); rst_n = 1'b1;
    v.push_back(mk(1, 5, 0, 0, 0, 5, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 5, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 4, 0, 1, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk_sys); #1;
      got = sample(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_pre[%0d]: got Y=%0d Tc=%b Busy=%b Done=%b, want Y=%0d Tc=%b Busy=%b Done=%b",
                 i, got.y, got.tc, got.busy, got.done, want.y, want.tc, want.busy, want.done);
      end
    end
    // Mid-cycle reset: outputs must clear with no clock edge in between.
    #2; rst_n = 1'b0;
    drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    #1;
    got = sample(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_async: got Y=%0d Tc=%b Busy=%b Done=%b, want all 0",
               got.y, got.tc, got.busy, got.done);
    end
    drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk_sys); #1;
    got = sample(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_held: got Y=%0d Tc=%b Busy=%b Done=%b, want all 0",
               got.y, got.tc, got.busy, got.done);
    end
    @(negedge clk_sys); rst_n = 1'b1;
    v.delete();
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk_sys); #1;
      got = sample(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_post[%0d]: got Y=%0d Tc=%b Busy=%b Done=%b, want Y=%0d Tc=%b Busy=%b Done=%b",
                 i, got.y, got.tc, got.busy, got.done, want.y, want.tc, want.busy, want.done);
      end
    end
  endtask

  task automatic test_one_shot();
    vec_t v[$];
    obs_t got, want;
    v.push_back(mk(1, 5, 0, 0, 0, 5, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 5, 0, 1, 0));
    for (int y = 4; y >= 1; y--) v.push_back(mk(0, 0, 0, 0, 0, y, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk_sys); #1;
      got = sample(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL one_shot[%0d]: got Y=%0d Tc=%b Busy=%b Done=%b, want Y=%0d Tc=%b Busy=%b Done=%b",
                 i, got.y, got.tc, got.busy, got.done, want.y, want.tc, want.busy, want.done);
      end
    end
  endtask

  task automatic test_auto_reload();
    vec_t v[$];
    obs_t got, want;
    v.push_back(mk(1, 3, 0, 0, 1, 3, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 1, 3, 0, 1, 0));
    for (int r = 0; r < 2; r++) begin
      v.push_back(mk(0, 0, 0, 0, 1, 2, 0, 1, 0));
      v.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0));
      v.push_back(mk(0, 0, 0, 0, 1, 3, 1, 1, 0));
    end
    v.push_back(mk(0, 0, 0, 0, 1, 2, 0, 1, 0));
    // Dropping Auto_Reload mid-count only changes the next terminal count.
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk_sys); #1;
      got = sample(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL auto_reload[%0d]: got Y=%0d Tc=%b Busy=%b Done=%b, want Y=%0d Tc=%b Busy=%b Done=%b",
                 i, got.y, got.tc, got.busy, got.done, want.y, want.tc, want.busy, want.done);
      end
    end
  endtask

  task automatic test_pause();
    vec_t v[$];
    obs_t got, want;
    v.push_back(mk(1, 6, 0, 0, 0, 6, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 6, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 5, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 4, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 4, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 4, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 2, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    v.push_back(mk(1, 5, 0, 0, 0, 5, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 5, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 5, 0, 1, 0));
    v.push_back(mk(1, 2, 0, 1, 0, 2, 0, 1, 0));   // load while held stays held
    v.push_back(mk(0, 0, 0, 1, 0, 2, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));   // terminal count beats Pause
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk_sys); #1;
      got = sample(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pause[%0d]: got Y=%0d Tc=%b Busy=%b Done=%b, want Y=%0d Tc=%b Busy=%b Done=%b",
                 i, got.y, got.tc, got.busy, got.done, want.y, want.tc, want.busy, want.done);
      end
    end
  endtask

  task automatic test_reload_mid_run();
    vec_t v[$];
    obs_t got, want;
    v.push_back(mk(1, 4, 0, 0, 0, 4, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 4, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 2, 0, 1, 0));
    v.push_back(mk(1, 9, 0, 0, 0, 9, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 8, 0, 1, 0));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 3, 1, 0, 0, 3, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 3, 0, 1, 0));
    v.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk_sys); #1;
      got = sample(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reload_mid_run[%0d]: got Y=%0d Tc=%b Busy=%b Done=%b, want Y=%0d Tc=%b Busy=%b Done=%b",
                 i, got.y, got.tc, got.busy, got.done, want.y, want.tc, want.busy, want.done);
      end
    end
  endtask

  task automatic test_start_rules();
    vec_t v[$];
    obs_t got, want;
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 7, 1, 0, 0, 7, 0, 1, 0));
    for (int y = 6; y >= 1; y--) v.push_back(mk(0, 0, 0, 0, 0, y, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    v.push_back(mk(0, 0, 1, 0, 0, 7, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 6, 0, 1, 0));
    v.push_back(mk(1, 4, 0, 0, 0, 4, 0, 1, 0));
    for (int y = 3; y >= 1; y--) v.push_back(mk(0, 0, 0, 0, 0, y, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    v.push_back(mk(0, 0, 1, 0, 0, 4, 0, 1, 0));
    for (int y = 3; y >= 1; y--) v.push_back(mk(0, 0, 0, 0, 0, y, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    v.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk_sys); #1;
      got = sample(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL start_rules[%0d]: got Y=%0d Tc=%b Busy=%b Done=%b, want Y=%0d Tc=%b Busy=%b Done=%b",
                 i, got.y, got.tc, got.busy, got.done, want.y, want.tc, want.busy, want.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    obs_t got, want;
    v.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    v.push_back(mk(1, 2, 1, 0, 0, 2, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    v.push_back(mk(1, 65535, 1, 0, 0, 65535, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 65534, 0, 1, 0));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk_sys); #1;
      got = sample(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got Y=%0d Tc=%b Busy=%b Done=%b, want Y=%0d Tc=%b Busy=%b Done=%b",
                 i, got.y, got.tc, got.busy, got.done, want.y, want.tc, want.busy, want.done);
      end
    end
  endtask

  initial begin
    bus.Load        = 1'b0;
    bus.Load_Val    = '0;
    bus.Start       = 1'b0;
    bus.Pause       = 1'b0;
    bus.Auto_Reload = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_reload_mid_run();
    test_start_rules();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
